// File: rtl/lg_reduce_pipe.sv
// lg_reduce_pipe: pipelined, masked N-input reduction gate (AND/NAND/OR/NOR/XOR/XNOR)
// with push-pull or open-collector output style and a saturating delivery counter.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready is combinational from out_ready)
//   in_data, in_mask      gate inputs and participation mask (WIDTH bits)
//   mode                  0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved (NAND + mode_err)
//   oc_en                 open-collector output style for this operand
//   out_valid / out_ready result handshake
//   y, y_oe, mode_err     registered result, drive enable, reserved-mode flag
//   txn_count             saturating count of delivered results
module lg_reduce_pipe #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned FANIN = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [2:0]       mode,
  input  logic             oc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic             y_oe,
  output logic             mode_err,
  output logic [CNT_W-1:0] txn_count
);

  // Number of live bits after l reduction levels.
  function automatic int unsigned lvl_w(input int unsigned l);
    int unsigned w;
    w = WIDTH;
    for (int unsigned i = 0; i < l; i++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  // Levels needed to reach a single bit, at least one.
  function automatic int unsigned calc_levels();
    int unsigned n;
    n = 0;
    while (lvl_w(n) > 1) n++;
    return (n == 0) ? 1 : n;
  endfunction

  // Bit offset of level l inside the flat level vector.
  function automatic int unsigned lvl_off(input int unsigned l);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < l; i++) s += lvl_w(i);
    return s;
  endfunction

  localparam int unsigned LEVELS  = calc_levels();
  localparam int unsigned TOT_W   = lvl_off(LEVELS + 1);
  localparam int unsigned RES_BIT = TOT_W - 1;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2
  } op_e;

  // Per-operand control carried alongside the data through every stage.
  typedef struct packed {
    logic valid;
    op_e  op;
    logic inv;
    logic err;
    logic oc;
  } ctl_t;

  ctl_t             in_ctl;
  ctl_t             ctl_q [0:LEVELS];
  logic [TOT_W-1:0] tdata;
  logic [TOT_W-1:0] tnext;
  logic             advance;
  logic             in_ident;

  // Every stage moves together; a stalled output freezes the whole pipe.
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;

  // Mode decode into base op, final inversion and reserved flag.
  always_comb begin
    in_ctl       = '0;
    in_ctl.valid = in_valid;
    in_ctl.oc    = oc_en;
    case (mode)
      3'd0:    in_ctl.op = OP_AND;
      3'd1:    begin in_ctl.op = OP_AND; in_ctl.inv = 1'b1; end
      3'd2:    in_ctl.op = OP_OR;
      3'd3:    begin in_ctl.op = OP_OR;  in_ctl.inv = 1'b1; end
      3'd4:    in_ctl.op = OP_XOR;
      3'd5:    begin in_ctl.op = OP_XOR; in_ctl.inv = 1'b1; end
      default: begin in_ctl.op = OP_AND; in_ctl.inv = 1'b1; in_ctl.err = 1'b1; end
    endcase
  end

  // Stage 0: masked-out inputs take the identity of the base op.
  assign in_ident         = (in_ctl.op == OP_AND);
  assign tnext[WIDTH-1:0] = in_ident ? (in_data | ~in_mask) : (in_data & in_mask);

  // Reduction tree: level l folds groups of FANIN bits of level l-1.
  for (genvar l = 1; l <= int'(LEVELS); l++) begin : g_lvl
    for (genvar g = 0; g < int'(lvl_w(l)); g++) begin : g_grp
      logic [FANIN-1:0] grp;
      logic             red;

      for (genvar k = 0; k < int'(FANIN); k++) begin : g_bit
        if (g * int'(FANIN) + k < int'(lvl_w(l - 1))) begin : g_src
          assign grp[k] = tdata[lvl_off(l - 1) + g * FANIN + k];
        end else begin : g_pad
          assign grp[k] = (ctl_q[l - 1].op == OP_AND);
        end
      end

      always_comb begin
        case (ctl_q[l - 1].op)
          OP_AND:  red = &grp;
          OP_OR:   red = |grp;
          default: red = ^grp;
        endcase
      end

      // Inverting modes flip the single bit produced by the last level.
      if (l == int'(LEVELS)) begin : g_last
        assign tnext[lvl_off(l) + g] = red ^ ctl_q[l - 1].inv;
      end else begin : g_mid
        assign tnext[lvl_off(l) + g] = red;
      end
    end
  end

  // Stage data and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata <= '0;
      for (int unsigned i = 0; i <= LEVELS; i++) ctl_q[i] <= '0;
    end else if (advance) begin
      tdata    <= tnext;
      ctl_q[0] <= in_ctl;
      for (int unsigned i = 1; i <= LEVELS; i++) ctl_q[i] <= ctl_q[i - 1];
    end
  end

  // Output stage: apply push-pull / open-collector style.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= 1'b0;
      y_oe      <= 1'b0;
      mode_err  <= 1'b0;
    end else if (advance) begin
      out_valid <= ctl_q[LEVELS].valid;
      if (ctl_q[LEVELS].valid) begin
        y        <= ctl_q[LEVELS].oc ? 1'b0 : tdata[RES_BIT];
        y_oe     <= ctl_q[LEVELS].oc ? ~tdata[RES_BIT] : 1'b1;
        mode_err <= ctl_q[LEVELS].err;
      end else begin
        y        <= 1'b0;
        y_oe     <= 1'b0;
        mode_err <= 1'b0;
      end
    end
  end

  // Saturating delivery counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (out_valid && out_ready && (txn_count != '1)) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule
